mod_exp_sqm: RTL and testbench

- Parametrised modular exponentiator res = base^exp mod modulus for the Diffie-Hellman key-exchange datapath.
- Successor to the repeated-multiply powering unit. Uses a left-to-right square-and-multiply schedule, so latency is O(N^2) cycles instead of O(2^N).
- Modulus is a runtime input, not a parameter. A constant-time mode is provided for secret exponents.
- Multiplication is done by a sequential shift-add modular multiplier. No `%` operator is used in the design.

---
 rtl/dh_pkg.sv | 21 ++
 rtl/mod_mul.sv | 93 +++++++++
 rtl/mod_exp_sqm.sv | 162 ++++++++++++++++
 tb/tb_mod_exp_sqm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman modular exponentiation datapath:
// controller state encoding, default width and index-width helper.
package dh_pkg;

   localparam int DEFAULT_N = 8;
   localparam int STATE_W   = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SQR  = 3'd2,
      ST_MUL  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Bits needed to hold an index 0..n-1 (never narrower than one bit).
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mod_mul.sv
// Sequential interleaved modular multiplier: p = a*b mod m, one b bit per cycle,
// MSB first. The first bit is folded into the start cycle so done lands at t+N.
module mod_mul
   import dh_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] m,
   output logic [N-1:0] p,
   output logic         done
);

   localparam int CW = idx_width(N);

   logic [N-1:0]  r_q, r_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  m_q, m_d;
   logic [N-1:0]  b_q, b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          active_q, active_d;
   logic          done_q, done_d;

   // One interleaved step; r < m and a < m keep every partial sum below 2m.
   function automatic logic [N-1:0] mm_step(input logic [N-1:0] r,
                                            input logic [N-1:0] aa,
                                            input logic [N-1:0] mm,
                                            input logic         bit_v);
      logic [N:0] t;
      t = {r, 1'b0};
      if (t >= {1'b0, mm}) t = t - {1'b0, mm};
      if (bit_v) begin
         t = t + {1'b0, aa};
         if (t >= {1'b0, mm}) t = t - {1'b0, mm};
      end
      return t[N-1:0];
   endfunction

   always_comb begin
      r_d      = r_q;
      a_d      = a_q;
      m_d      = m_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      done_d   = 1'b0;
      if (start) begin
         a_d      = a;
         m_d      = m;
         b_d      = b << 1;
         r_d      = mm_step('0, a, m, b[N-1]);
         cnt_d    = CW'(N-1);
         active_d = 1'b1;
      end else if (active_q) begin
         r_d   = mm_step(r_q, a_q, m_q, b_q[N-1]);
         b_d   = b_q << 1;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q      <= '0;
         a_q      <= '0;
         m_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else if (ena) begin
         r_q      <= r_d;
         a_q      <= a_d;
         m_q      <= m_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign p    = r_q;
   assign done = done_q;

endmodule

// File: rtl/mod_exp_sqm.sv
// Left-to-right square-and-multiply modular exponentiator res = base^exp mod modulus.
// Optional constant-time schedule runs the multiply for every exponent bit.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | operand check, acc/index init
// SQR   | acc <= acc*acc mod m
// MUL   | acc*base mod m, kept only when exp[i]=1
// DONE  | rdy pulse, result published
module mod_exp_sqm
   import dh_pkg::*;
#(
   parameter int N          = DEFAULT_N,
   parameter bit CONST_TIME = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         start,
   input  logic [N-1:0] base,
   input  logic [N-1:0] exp,
   input  logic [N-1:0] modulus,
   output logic [N-1:0] res,
   output logic         rdy,
   output logic         busy,
   output logic         err
);

   localparam int IW = idx_width(N);

   state_e        state_q, state_d;
   logic [N-1:0]  base_q, base_d;
   logic [N-1:0]  exp_q, exp_d;
   logic [N-1:0]  mod_q, mod_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          issued_q, issued_d;
   logic [N-1:0]  res_q, res_d;
   logic          err_q, err_d;

   logic          mul_start;
   logic [N-1:0]  mul_b;
   logic [N-1:0]  mul_p;
   logic          mul_done;
   logic [N-1:0]  mul_keep;

   assign mul_b    = (state_q == ST_MUL) ? base_q : acc_q;
   assign mul_keep = exp_q[idx_q] ? mul_p : acc_q;

   mod_mul #(.N(N)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .start (mul_start),
      .a     (acc_q),
      .b     (mul_b),
      .m     (mod_q),
      .p     (mul_p),
      .done  (mul_done)
   );

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      exp_d     = exp_q;
      mod_d     = mod_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      issued_d  = issued_q;
      res_d     = res_q;
      err_d     = err_q;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = base;
               exp_d   = exp;
               mod_d   = modulus;
               err_d   = 1'b0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (mod_q == '0 || base_q >= mod_q) begin
               err_d   = 1'b1;
               res_d   = '0;
               state_d = ST_DONE;
            end else begin
               acc_d   = (mod_q == N'(1)) ? '0 : N'(1);
               idx_d   = IW'(N-1);
               state_d = ST_SQR;
            end
         end
         ST_SQR: begin
            if (!issued_q) begin
               mul_start = 1'b1;
               issued_d  = 1'b1;
            end else if (mul_done) begin
               issued_d = 1'b0;
               acc_d    = mul_p;
               if (exp_q[idx_q] || CONST_TIME) begin
                  state_d = ST_MUL;
               end else if (idx_q == '0) begin
                  res_d   = mul_p;
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end
         end
         ST_MUL: begin
            if (!issued_q) begin
               mul_start = 1'b1;
               issued_d  = 1'b1;
            end else if (mul_done) begin
               // Constant-time dummy multiply: product dropped when the bit is 0.
               issued_d = 1'b0;
               acc_d    = mul_keep;
               if (idx_q == '0) begin
                  res_d   = mul_keep;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q - IW'(1);
                  state_d = ST_SQR;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         base_q   <= '0;
         exp_q    <= '0;
         mod_q    <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         issued_q <= 1'b0;
         res_q    <= '0;
         err_q    <= 1'b0;
      end else if (ena) begin
         state_q  <= state_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         mod_q    <= mod_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         issued_q <= issued_d;
         res_q    <= res_d;
         err_q    <= err_d;
      end
   end

   assign res  = res_q;
   assign err  = err_q;
   assign rdy  = (state_q == ST_DONE);
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod_exp_sqm.sv
// Bench for mod_exp_sqm: directed and random operations on three configurations
// (N=8 constant-time, N=8 variable-time, N=16 variable-time) against a plain-arithmetic model.
module tb_mod_exp_sqm;

   logic        clk = 1'b0;
   logic        rst, ena;
   logic [15:0] base_v, exp_v, mod_v;
   logic        start0, start1, start2;
   logic [7:0]  res0, res1;
   logic [15:0] res2;
   logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, err0, err1, err2;

   int          sel;
   logic [15:0] res_s;
   logic        rdy_s, busy_s, err_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mod_exp_sqm #(.N(8), .CONST_TIME(1'b1)) u_ct8 (
      .clk(clk), .rst(rst), .ena(ena), .start(start0),
      .base(base_v[7:0]), .exp(exp_v[7:0]), .modulus(mod_v[7:0]),
      .res(res0), .rdy(rdy0), .busy(busy0), .err(err0));

   mod_exp_sqm #(.N(8), .CONST_TIME(1'b0)) u_vt8 (
      .clk(clk), .rst(rst), .ena(ena), .start(start1),
      .base(base_v[7:0]), .exp(exp_v[7:0]), .modulus(mod_v[7:0]),
      .res(res1), .rdy(rdy1), .busy(busy1), .err(err1));

   mod_exp_sqm #(.N(16), .CONST_TIME(1'b0)) u_vt16 (
      .clk(clk), .rst(rst), .ena(ena), .start(start2),
      .base(base_v), .exp(exp_v), .modulus(mod_v),
      .res(res2), .rdy(rdy2), .busy(busy2), .err(err2));

   always_comb begin
      res_s  = 16'(res0);
      rdy_s  = rdy0;
      busy_s = busy0;
      err_s  = err0;
      case (sel)
         1: begin res_s = 16'(res1); rdy_s = rdy1; busy_s = busy1; err_s = err1; end
         2: begin res_s = res2;      rdy_s = rdy2; busy_s = busy2; err_s = err2; end
         default: ;
      endcase
   end

   task automatic check(input string tag, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic longint ref_pow(input longint b, input longint e, input longint m, input int n);
      longint r;
      if (m == 0 || b >= m) return 0;
      r = (m == 1) ? 0 : 1;
      for (int i = n - 1; i >= 0; i--) begin
         r = (r * r) % m;
         if (e[i]) r = (r * b) % m;
      end
      return r;
   endfunction

   function automatic int ref_lat(input longint b, input longint e, input longint m,
                                  input int n, input bit ct);
      int pop;
      if (m == 0 || b >= m) return 2;
      pop = 0;
      for (int i = 0; i < n; i++) if (e[i]) pop++;
      return ct ? 2 + n * (2 * n + 2) : 2 + n * (n + 1) + pop * (n + 1);
   endfunction

   task automatic drive_start(input int d, input logic v);
      start0 = v && (d == 0);
      start1 = v && (d == 1);
      start2 = v && (d == 2);
   endtask

   // One operation on DUT d; optional ena-low window and a stray start while busy.
   task automatic run_op(input string tag, input int d, input longint b, input longint e,
                         input longint m, input int ena_at, input int ena_len, input int poke_at);
      int     n, k, want_lat;
      bit     ct, busy_ok;
      longint want_res;
      n = (d == 2) ? 16 : 8;
      ct = (d == 0);
      want_res = ref_pow(b, e, m, n);
      want_lat = ref_lat(b, e, m, n, ct) + ena_len;
      sel = d;
      @(posedge clk); #1;
      check({tag, "_idle_rdy"}, rdy_s, 0);
      check({tag, "_idle_busy"}, busy_s, 0);
      base_v = 16'(b); exp_v = 16'(e); mod_v = 16'(m);
      drive_start(d, 1'b1);
      @(posedge clk); #1;
      drive_start(d, 1'b0);
      base_v = 16'($urandom); exp_v = 16'($urandom); mod_v = 16'($urandom);
      k = 1;
      busy_ok = 1'b1;
      while (!rdy_s && k < 4000) begin
         if (!busy_s) busy_ok = 1'b0;
         if (k == ena_at) ena = 1'b0;
         if (k == ena_at + ena_len) ena = 1'b1;
         if (k == poke_at) begin
            base_v = 16'($urandom); exp_v = 16'($urandom); mod_v = 16'($urandom | 1);
            drive_start(d, 1'b1);
         end
         if (k == poke_at + 1) drive_start(d, 1'b0);
         @(posedge clk); #1;
         k++;
      end
      ena = 1'b1;
      drive_start(d, 1'b0);
      check({tag, "_lat"}, k, want_lat);
      check({tag, "_busy"}, busy_ok && busy_s, 1);
      check({tag, "_res"}, res_s, want_res);
      check({tag, "_err"}, err_s, (m == 0 || b >= m) ? 1 : 0);
   endtask

   task automatic rand_op(input int d);
      int     n;
      longint m, b, e, mask;
      n = (d == 2) ? 16 : 8;
      mask = (longint'(1) << n) - 1;
      m = longint'($urandom_range(1, 32'(mask)));
      if ($urandom_range(0, 3) == 0) m = longint'($urandom_range(1, 5));
      b = longint'($urandom) % m;
      e = longint'($urandom) & mask;
      case ($urandom_range(0, 9))
         0: m = 0;
         1: b = m + (longint'($urandom) % (mask - m + 1));
         default: ;
      endcase
      run_op("rnd", d, b, e, m, 0, 0, 0);
   endtask

   initial begin
      int hits;
      rst = 1'b1; ena = 1'b1; sel = 0;
      base_v = '0; exp_v = '0; mod_v = '0;
      drive_start(0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy", {rdy0, rdy1, rdy2}, 0);
      check("rst_busy", {busy0, busy1, busy2}, 0);
      check("rst_err", {err0, err1, err2}, 0);
      check("rst_res", {res0, res1, res2}, 0);
      rst = 1'b0;

      run_op("ct8_3_5_7", 0, 3, 5, 7, 0, 0, 0);
      run_op("b2b_a", 0, 5, 6, 23, 0, 0, 0);
      run_op("b2b_b", 0, 5, 15, 23, 0, 0, 0);
      run_op("exp0", 0, 2, 0, 11, 0, 0, 0);
      run_op("mod1", 0, 0, 0, 1, 0, 0, 0);
      run_op("base0", 0, 0, 3, 7, 0, 0, 0);
      run_op("err_mod0", 0, 5, 3, 0, 0, 0, 0);
      run_op("err_big", 0, 9, 3, 7, 0, 0, 0);
      run_op("err_clr", 0, 3, 5, 7, 0, 0, 0);
      run_op("poke", 0, 5, 15, 23, 0, 0, 30);
      run_op("ena_gap", 0, 5, 6, 23, 40, 10, 0);
      run_op("vt8_3_5_7", 1, 3, 5, 7, 0, 0, 0);
      run_op("vt16_ena", 2, 1234, 40001, 65521, 100, 7, 0);

      // Abort in SQR: outputs clear and no rdy follows.
      run_op("pre_rst", 0, 5, 6, 23, 0, 0, 0);
      sel = 0;
      @(posedge clk); #1;
      base_v = 16'd3; exp_v = 16'd5; mod_v = 16'd7;
      drive_start(0, 1'b1);
      @(posedge clk); #1;
      drive_start(0, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_rdy", rdy0, 0);
      check("abort_busy", busy0, 0);
      check("abort_res", res0, 0);
      check("abort_err", err0, 0);
      hits = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (rdy0 || busy0) hits++;
      end
      check("abort_quiet", hits, 0);

      for (int i = 0; i < 5; i++)  rand_op(0);
      for (int i = 0; i < 25; i++) rand_op(1);
      for (int i = 0; i < 20; i++) rand_op(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
